// File: rtl/dacq_ascii_pkg.sv
// Shared ASCII definitions for the data-acquisition UART path: character constants,
// type/id mapping, unit characters and the line-parser state encoding.
package dacq_ascii_pkg;

  localparam logic [7:0] ASCII_COLON      = 8'h3A;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;

  localparam logic [7:0] UNIT_MILLI   = "m";
  localparam logic [7:0] UNIT_CELSIUS = "C";
  localparam logic [7:0] UNIT_COUNT   = "#";
  localparam logic [7:0] UNIT_SECOND  = "s";

  typedef enum logic [2:0] {
    ST_WAIT_TYPE,
    ST_WAIT_COLON,
    ST_DIGITS,
    ST_WAIT_CR,
    ST_WAIT_LF,
    ST_EMIT,
    ST_DISCARD
  } parse_state_t;

  function automatic logic type_valid(input logic [7:0] c);
    return (c == "V") || (c == "T") || (c == "B") || (c == "A") || (c == "R");
  endfunction

  function automatic logic [2:0] type_to_id(input logic [7:0] c);
    case (c)
      "T":     return 3'd1;
      "B":     return 3'd2;
      "A":     return 3'd3;
      "R":     return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] id_to_type(input logic [2:0] id);
    case (id)
      3'd0:    return "V";
      3'd1:    return "T";
      3'd2:    return "B";
      3'd3:    return "A";
      3'd4:    return "R";
      default: return "?";
    endcase
  endfunction

  function automatic logic is_unit(input logic [7:0] c);
    return (c == UNIT_MILLI) || (c == UNIT_CELSIUS) || (c == UNIT_COUNT) || (c == UNIT_SECOND);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_DIGIT_BASE) && (c <= ASCII_DIGIT_BASE + 8'd9);
  endfunction

endpackage

// File: rtl/uart_dec_accum.sv
// Decimal accumulator: builds a 16-bit value one digit at a time and flags a digit
// that would exceed five digits or 65535 before it is applied.
module uart_dec_accum (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic [15:0] acc,
  output logic        overflow,
  output logic [2:0]  ndig
);

  logic [19:0] next_acc;

  always_comb begin
    next_acc = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {16'h0000, digit};
    overflow = digit_valid && ((ndig == 3'd5) || (next_acc > 20'd65535));
  end

  // An overflowing digit leaves acc untouched; the parser abandons the line anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      ndig <= '0;
    end else if (clear) begin
      acc  <= '0;
      ndig <= '0;
    end else if (digit_valid && !overflow) begin
      acc  <= next_acc[15:0];
      ndig <= ndig + 3'd1;
    end
  end

endmodule

// File: rtl/uart_parser.sv
// Parses "<type>:<digits>[unit][CR]LF" lines from a UART byte stream into one
// AXI4-Stream beat per valid line; malformed lines are dropped and counted.
module uart_parser
  import dacq_ascii_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  s_uart_tdata,
  input  logic        s_uart_tvalid,
  output logic        s_uart_tready,
  output logic [31:0] m_axis_tdata,
  output logic [2:0]  m_axis_tid,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        parse_error,
  output logic [15:0] err_count
);

  parse_state_t state;
  logic [2:0]   id;
  logic [15:0]  acc;
  logic [2:0]   ndig;
  logic         overflow;
  logic         accept;
  logic         byte_is_cr;
  logic         byte_is_lf;
  logic         bad_byte;
  logic         line_done;
  logic         digit_valid;
  logic         acc_clear;

  assign accept     = s_uart_tvalid && s_uart_tready;
  assign byte_is_cr = (s_uart_tdata == ASCII_CR);
  assign byte_is_lf = (s_uart_tdata == ASCII_LF);

  assign digit_valid = accept && (state == ST_DIGITS) && is_digit(s_uart_tdata);
  assign acc_clear   = accept && (state == ST_WAIT_COLON) && (s_uart_tdata == ASCII_COLON);

  uart_dec_accum u_accum (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (acc_clear),
    .digit_valid (digit_valid),
    .digit       (s_uart_tdata[3:0]),
    .acc         (acc),
    .overflow    (overflow),
    .ndig        (ndig)
  );

  always_comb begin
    // NOTE: default assigned before the case so no path leaves bad_byte unassigned (no latch).
    bad_byte = 1'b0;
    case (state)
      ST_WAIT_TYPE:  bad_byte = !type_valid(s_uart_tdata) && !byte_is_cr && !byte_is_lf;
      ST_WAIT_COLON: bad_byte = (s_uart_tdata != ASCII_COLON);
      ST_DIGITS:
        if (is_digit(s_uart_tdata)) bad_byte = overflow;
        else bad_byte = (ndig == 3'd0) ||
                        !(is_unit(s_uart_tdata) || byte_is_cr || byte_is_lf);
      ST_WAIT_CR:    bad_byte = !byte_is_cr && !byte_is_lf;
      ST_WAIT_LF:    bad_byte = !byte_is_lf;
      default:       bad_byte = 1'b0;
    endcase
  end

  assign line_done = accept && !bad_byte && byte_is_lf &&
                     ((state == ST_DIGITS) || (state == ST_WAIT_CR) || (state == ST_WAIT_LF));

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_WAIT_TYPE;
      id            <= '0;
      s_uart_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      parse_error   <= 1'b0;
      err_count     <= '0;
    end else begin
      parse_error <= accept && bad_byte;
      if (accept && bad_byte && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;

      if (state == ST_EMIT) begin
        // Input stays closed until the beat is taken, so the handshake cycle accepts no byte.
        if (m_axis_tready) begin
          state         <= ST_WAIT_TYPE;
          m_axis_tvalid <= 1'b0;
          s_uart_tready <= 1'b1;
        end
      end else if (line_done) begin
        state         <= ST_EMIT;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {16'h0000, acc};
        m_axis_tid    <= id;
        s_uart_tready <= 1'b0;
      end else begin
        s_uart_tready <= 1'b1;
        if (accept) begin
          if (bad_byte) begin
            state <= byte_is_lf ? ST_WAIT_TYPE : ST_DISCARD;
          end else begin
            case (state)
              ST_WAIT_TYPE:
                if (type_valid(s_uart_tdata)) begin
                  id    <= type_to_id(s_uart_tdata);
                  state <= ST_WAIT_COLON;
                end
              ST_WAIT_COLON: state <= ST_DIGITS;
              ST_DIGITS:
                if (is_unit(s_uart_tdata)) state <= ST_WAIT_CR;
                else if (byte_is_cr)       state <= ST_WAIT_LF;
              ST_WAIT_CR:
                if (byte_is_cr) state <= ST_WAIT_LF;
              ST_DISCARD:
                if (byte_is_lf) state <= ST_WAIT_TYPE;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_parser.sv
// Bench for uart_parser: directed lines plus random lines, each scored against a
// line-level grammar model of the text protocol.
`timescale 1ns/1ps
module tb_uart_parser;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit err;
    int err_pos;
    bit beat;
    int tid;
    int val;
  } line_res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_uart_tdata = 8'h00;
  logic        s_uart_tvalid = 1'b0;
  logic        s_uart_tready;
  logic [31:0] m_axis_tdata;
  logic [2:0]  m_axis_tid;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        parse_error;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  uart_parser dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_uart_tdata  (s_uart_tdata),
    .s_uart_tvalid (s_uart_tvalid),
    .s_uart_tready (s_uart_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .parse_error   (parse_error),
    .err_count     (err_count)
  );

  int total = 0;
  int passed = 0;
  int bytes_accepted = 0;
  int exp_err_count = 0;
  int err_idx[$];
  logic [34:0] beats[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (parse_error) err_idx.push_back(bytes_accepted - 1);
      if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tid, m_axis_tdata});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bq_t str_bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic int find_char(input string set, input logic [7:0] c);
    for (int k = 0; k < set.len(); k++) if (set[k] == c) return k;
    return -1;
  endfunction

  // Grammar: CR* type ':' digit{1,5} unit? CR? LF, value <= 65535; a line of only CR/LF is blank.
  function automatic line_res_t model_line(input bq_t q);
    line_res_t r;
    int i;
    int n;
    int v;
    r = '{err: 1'b0, err_pos: -1, beat: 1'b0, tid: 0, val: 0};
    i = 0;
    while (q[i] == 8'h0D) i++;
    if (q[i] == 8'h0A) return r;
    r.tid = find_char("VTBAR", q[i]);
    if (r.tid < 0) begin r.err = 1; r.err_pos = i; return r; end
    i++;
    if (q[i] != ":") begin r.err = 1; r.err_pos = i; return r; end
    i++;
    n = 0;
    v = 0;
    while (q[i] >= "0" && q[i] <= "9") begin
      if (n == 5 || v * 10 + int'(q[i] - "0") > 65535) begin
        r.err = 1; r.err_pos = i; return r;
      end
      v = v * 10 + int'(q[i] - "0");
      n++;
      i++;
    end
    if (n == 0) begin r.err = 1; r.err_pos = i; return r; end
    if (find_char("mC#s", q[i]) >= 0) i++;
    if (q[i] == 8'h0D) i++;
    if (q[i] != 8'h0A) begin r.err = 1; r.err_pos = i; return r; end
    r.beat = 1;
    r.val = v;
    return r;
  endfunction

  function automatic bq_t rand_line();
    bq_t q;
    string types = "VTBARQx:";
    string units = "mC#sZ";
    int nd;
    int k;
    if ($urandom_range(14) == 0) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
    end
    if ($urandom_range(9) == 0) q.push_back(8'h0D);
    k = ($urandom_range(9) < 8) ? int'($urandom_range(4)) : int'($urandom_range(7));
    q.push_back(types[k]);
    q.push_back(($urandom_range(19) == 0) ? 8'h2D : 8'h3A);
    nd = $urandom_range(6);
    if ($urandom_range(3) == 0) begin
      q.push_back("6");
      nd = 4;
    end
    for (int j = 0; j < nd; j++) q.push_back(8'(48 + $urandom_range(9)));
    k = $urandom_range(5);
    if (k < 5) q.push_back(units[k]);
    if ($urandom_range(1) == 1) q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    s_uart_tdata  = b;
    s_uart_tvalid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = s_uart_tready;
      @(posedge clk);
      #1;
    end
    s_uart_tvalid = 1'b0;
    if (done) bytes_accepted++;
    else check("byte_accepted", {63'd0, done}, 64'd1);
  endtask

  task automatic run_line(input string tag, input bq_t q);
    line_res_t r;
    int base;
    r = model_line(q);
    err_idx.delete();
    beats.delete();
    base = bytes_accepted;
    foreach (q[i]) send_byte(q[i]);
    repeat (4) @(posedge clk);
    #1;
    if (r.err && exp_err_count < 65535) exp_err_count++;
    check({tag, "/err_pulses"}, 64'(err_idx.size()), r.err ? 64'd1 : 64'd0);
    if (r.err && err_idx.size() == 1)
      check({tag, "/err_byte"}, 64'(err_idx[0]), 64'(base + r.err_pos));
    check({tag, "/beats"}, 64'(beats.size()), r.beat ? 64'd1 : 64'd0);
    if (r.beat && beats.size() == 1)
      check({tag, "/beat"}, 64'(beats[0]), 64'({3'(r.tid), 16'h0000, 16'(r.val)}));
    check({tag, "/err_count"}, 64'(err_count), 64'(exp_err_count));
  endtask

  initial begin
    bq_t q;
    repeat (3) @(posedge clk);
    #1;
    check("rst/s_tready", 64'(s_uart_tready), 64'd0);
    check("rst/tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst/tdata", 64'(m_axis_tdata), 64'd0);
    check("rst/tid", 64'(m_axis_tid), 64'd0);
    check("rst/parse_error", 64'(parse_error), 64'd0);
    check("rst/err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_line("T123", str_bytes("T:00123C\015\012"));
    run_line("V65535", str_bytes("V:65535m\012"));
    run_line("V65536", str_bytes("V:65536m\015\012"));
    run_line("Q1", str_bytes("Q:1\015\012"));
    run_line("R7", str_bytes("R:7\015\012"));
    run_line("T6dig", str_bytes("T:123456C\015\012"));
    run_line("no_digits", str_bytes("A:\012"));
    run_line("blank", str_bytes("\015\012"));

    // Downstream stall: beat must hold steady and the byte input must stay closed.
    m_axis_tready = 1'b0;
    err_idx.delete();
    beats.delete();
    q = str_bytes("A:42#\015\012");
    foreach (q[i]) send_byte(q[i]);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall/tvalid", 64'(m_axis_tvalid), 64'd1);
      check("stall/tid", 64'(m_axis_tid), 64'd3);
      check("stall/tdata", 64'(m_axis_tdata), 64'd42);
      check("stall/s_tready", 64'(s_uart_tready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall/beats", 64'(beats.size()), 64'd1);
    if (beats.size() == 1) check("stall/beat", 64'(beats[0]), 64'({3'd3, 32'd42}));
    check("stall/err_pulses", 64'(err_idx.size()), 64'd0);
    run_line("B9", str_bytes("B:9\012"));

    for (int n = 0; n < 60; n++) run_line($sformatf("rand%0d", n), rand_line());

    // Reset in the middle of a line discards it and clears the error count.
    q = str_bytes("B:12");
    foreach (q[i]) send_byte(q[i]);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst/s_tready", 64'(s_uart_tready), 64'd0);
    check("midrst/tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst/tdata", 64'(m_axis_tdata), 64'd0);
    check("midrst/tid", 64'(m_axis_tid), 64'd0);
    check("midrst/parse_error", 64'(parse_error), 64'd0);
    check("midrst/err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_err_count = 0;
    repeat (2) @(posedge clk);
    #1;
    run_line("B5", str_bytes("B:5\015\012"));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
